seg7_scan_ctrl: RTL and testbench

//   Time-multiplexes NUM_DIGITS BCD digits through one shared digit-to-7-segment decoder
//   (digit in, segments g..a out) onto a common-segment display for the dice result.

---
 rtl/seg7_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit slot timing with anti-ghost blanking,
// leading-zero suppression and a frame-aligned double buffer for the displayed value.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic                    lz_blank,
    output logic [3:0]              dec_digit,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNTW = $clog2(REFRESH_DIV);
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                  state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pending_q, pending_d;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] nib;
    logic       upper_zero;
    logic       suppress;
    logic       show;

    assign slot_end  = (cnt_q == CNTW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx_q == IDXW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNTW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (slot_end) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = frame_end ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // A load on the boundary cycle lands in pending after the transfer, so it survives.
    always_comb begin
        active_d  = active_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (pending_q) active_d = pend_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_d    = value_bcd;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        nib        = '0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i == 32'(idx_q)) nib = active_q[4*i +: 4];
            if (i >= 32'(idx_q) && active_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        suppress = (nib > 4'd9) || (lz_blank && (idx_q != '0) && upper_zero);
    end

    assign show       = (state_q == ST_SHOW) && !suppress;
    assign dec_digit  = nib;
    assign an_out     = show ? (NUM_DIGITS'(1) << idx_q) : '0;
    assign seg_out    = show ? dec_seg : '0;
    assign frame_done = frame_end;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (2 digits, 8-clock slots, 2 blank clocks) with an ideal decoder
// and a cycle-level reference model feeding an expected-output queue.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] value_bcd;
    logic       lz_blank;
    logic [3:0] dec_digit;
    logic [6:0] dec_seg;
    logic [6:0] seg_out;
    logic [1:0] an_out;
    logic       frame_done;
    logic       pending;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] dig;
        logic [1:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       pnd;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int         m_cnt;
    int         m_idx;
    logic [7:0] m_active;
    logic [7:0] m_pend;
    logic       m_pending;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (2),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value_bcd (value_bcd),
        .lz_blank  (lz_blank),
        .dec_digit (dec_digit),
        .dec_seg   (dec_seg),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b0111111;
            4'd1: seg7 = 7'b0000110;
            4'd2: seg7 = 7'b1011011;
            4'd3: seg7 = 7'b1001111;
            4'd4: seg7 = 7'b1100110;
            4'd5: seg7 = 7'b1101101;
            4'd6: seg7 = 7'b1111101;
            4'd7: seg7 = 7'b0000111;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1101111;
            default: seg7 = 7'bxxxxxxx;
        endcase
    endfunction

    assign dec_seg = seg7(dec_digit);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_active = '0; m_pend = '0; m_pending = 1'b0;
    endtask

    // Entered at a negedge; drives one cycle of inputs, checks, advances the model.
    task automatic step(input logic ld, input logic [7:0] val, input logic lz);
        exp_t       e;
        logic [3:0] n;
        logic       supp, shw;
        load = ld; value_bcd = val; lz_blank = lz;
        #1;
        n     = (m_idx == 1) ? m_active[7:4] : m_active[3:0];
        supp  = (n > 4'd9) || (lz && m_idx == 1 && n == 4'd0);
        shw   = (m_cnt >= 2) && !supp;
        e.dig = n;
        e.an  = shw ? ((m_idx == 1) ? 2'b10 : 2'b01) : 2'b00;
        e.seg = shw ? seg7(n) : 7'b0;
        e.fd  = (m_cnt == 7) && (m_idx == 1);
        e.pnd = m_pending;
        sb.push_back(e);
        e = sb.pop_front();
        chk("dec_digit", 32'(dec_digit), 32'(e.dig));
        chk("an_out", 32'(an_out), 32'(e.an));
        chk("seg_out", 32'(seg_out), 32'(e.seg));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("pending", 32'(pending), 32'(e.pnd));
        if (e.fd) begin
            if (m_pending) m_active = m_pend;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_pend = val;
            m_pending = 1'b1;
        end
        if (m_cnt == 7) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 2;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n, input logic lz);
        for (int k = 0; k < n; k++) step(1'b0, 8'hFF, lz);
    endtask

    // Advance until the next step is the frame_done cycle.
    task automatic run_to_fd(input logic lz);
        for (int k = 0; k < 32 && !(m_cnt == 7 && m_idx == 1); k++) step(1'b0, 8'hFF, lz);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value_bcd = '0; lz_blank = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_an", 32'(an_out), 32'h0);
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Frame 0 from reset, value 0, slot 1 zero-suppressed
        steps(16, 1'b1);

        // Load 0x42 mid-frame; old value stays until boundary
        steps(3, 1'b1);
        step(1'b1, 8'h42, 1'b1);
        run_to_fd(1'b1);
        step(1'b0, 8'hFF, 1'b1);
        steps(16, 1'b1);

        // 0x07 with and without leading-zero blanking
        step(1'b1, 8'h07, 1'b1);
        run_to_fd(1'b1);
        steps(17, 1'b1);
        steps(16, 1'b0);

        // Non-BCD nibble in slot 1
        run_to_fd(1'b0);
        step(1'b1, 8'hA3, 1'b0);
        steps(16, 1'b0);

        // Two loads in a frame, then a load on the boundary cycle
        step(1'b1, 8'h11, 1'b1);
        steps(4, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        run_to_fd(1'b1);
        step(1'b1, 8'h35, 1'b1);
        steps(16, 1'b1);
        step(1'b0, 8'hFF, 1'b1);
        steps(16, 1'b1);

        // Async reset during SHOW with a value pending
        step(1'b1, 8'h58, 1'b1);
        steps(4, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_an", 32'(an_out), 32'h0);
        chk("async_seg", 32'(seg_out), 32'h0);
        chk("async_pending", 32'(pending), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        steps(20, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
